out_timing_ctrl: RTL and testbench

OUT_TIMING_CTRL -- requirements
Module: out_timing_ctrl

---
 rtl/out_timing_ctrl_pkg.sv | 59 +++++
 rtl/out_timing_ctrl_if.sv | 20 ++
 rtl/out_timing_cfg_check.sv | 25 ++
 rtl/out_timing_ctrl.sv | 154 +++++++++++++++
 tb/tb_out_timing_ctrl.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/out_timing_ctrl_pkg.sv
// Shared types and constants for the output timing controller:
// FSM encoding, config register map and reset-default timing set.
package out_timing_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARM  = 2'd1,
      ST_RUN  = 2'd2
   } state_t;

   localparam logic [2:0] CFG_VTOT     = 3'd0;
   localparam logic [2:0] CFG_V_ACTIVE = 3'd1;
   localparam logic [2:0] CFG_V_WAIT   = 3'd2;
   localparam logic [2:0] CFG_H_ACTIVE = 3'd3;
   localparam logic [2:0] CFG_H_WAIT   = 3'd4;
   localparam logic [2:0] CFG_HSW      = 3'd5;
   localparam logic [2:0] CFG_VSW      = 3'd6;

   localparam logic [8:0] CNT_MAX = 9'd511;

   typedef struct packed {
      logic [8:0] vtot;
      logic [8:0] v_active_th;
      logic [8:0] v_wait_th;
      logic [8:0] h_active_th;
      logic [8:0] h_wait_th;
      logic [5:0] hsw;
      logic [5:0] vsw;
   } cfg_set_t;

   localparam cfg_set_t CFG_DEFAULT = '{
      vtot:        9'd288,
      v_active_th: 9'd280,
      v_wait_th:   9'd8,
      h_active_th: 9'd488,
      h_wait_th:   9'd8,
      hsw:         6'd4,
      vsw:         6'd2
   };

   // Merge one register write into a timing set; the reserved address leaves it untouched.
   function automatic cfg_set_t cfg_write(input cfg_set_t cur, input logic [2:0] addr,
                                          input logic [8:0] data);
      cfg_set_t nxt;
      nxt = cur;
      case (addr)
         CFG_VTOT:     nxt.vtot        = data;
         CFG_V_ACTIVE: nxt.v_active_th = data;
         CFG_V_WAIT:   nxt.v_wait_th   = data;
         CFG_H_ACTIVE: nxt.h_active_th = data;
         CFG_H_WAIT:   nxt.h_wait_th   = data;
         CFG_HSW:      nxt.hsw         = data[5:0];
         CFG_VSW:      nxt.vsw         = data[5:0];
         default:      nxt             = cur;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/out_timing_ctrl_if.sv
// Configuration bus of the output timing controller: shadow writes,
// commit request and commit status.
interface out_timing_ctrl_if;
   logic       i_cfg_wr;
   logic [2:0] i_cfg_addr;
   logic [8:0] i_cfg_data;
   logic       i_cfg_commit;
   logic       o_cfg_pending;
   logic       o_cfg_err;

   modport master (
      output i_cfg_wr, i_cfg_addr, i_cfg_data, i_cfg_commit,
      input  o_cfg_pending, o_cfg_err
   );

   modport slave (
      input  i_cfg_wr, i_cfg_addr, i_cfg_data, i_cfg_commit,
      output o_cfg_pending, o_cfg_err
   );
endinterface

// File: rtl/out_timing_cfg_check.sv
// Combinational consistency check of a candidate timing set; cfg_valid=1
// means the set may be committed.
module out_timing_cfg_check
   import out_timing_ctrl_pkg::*;
(
   input  cfg_set_t shadow,
   output logic     cfg_valid
);

   // Every wait threshold must sit inside its active window and VTOT+1 must stay representable.
   always_comb begin
      cfg_valid = 1'b1;
      if ((shadow.h_wait_th >= shadow.h_active_th) ||
          (shadow.v_wait_th >= shadow.v_active_th) ||
          (shadow.v_active_th > shadow.vtot)       ||
          (shadow.vtot == 9'd511)                  ||
          (shadow.vsw == 6'd0)                     ||
          (shadow.hsw == 6'd0)) begin
         cfg_valid = 1'b0;
      end else begin
         cfg_valid = 1'b1;
      end
   end

endmodule

// File: rtl/out_timing_ctrl.sv
// Output timing controller: line/frame counters driven by i_hsync edges and a
// shadow/active timing register set with validated, frame-synchronous commits.
module out_timing_ctrl
   import out_timing_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              i_reset,
   input  logic              i_en,
   input  logic              i_hsync,
   out_timing_ctrl_if.slave  cfg,
   output logic [8:0]        o_hsync_cnt,
   output logic [8:0]        o_vsync_cnt,
   output logic              o_hsync_edge,
   output logic              o_frame_start,
   output logic [8:0]        o_VTOT,
   output logic [8:0]        o_V_ACTIVE_TH,
   output logic [8:0]        o_V_WAIT_TH,
   output logic [8:0]        o_H_ACTIVE_TH,
   output logic [8:0]        o_H_WAIT_TH,
   output logic [5:0]        o_hsw,
   output logic [5:0]        o_vsw
);

   state_t     state_r, state_nxt_s;
   logic       hsync_r, edge_s, line_wrap_s;
   logic [8:0] hcnt_r, hcnt_nxt_s, vcnt_r, vcnt_nxt_s;
   logic       hedge_r, hedge_nxt_s, frame_r, frame_nxt_s;
   cfg_set_t   shadow_r, shadow_nxt_s, active_r;
   logic       pending_r, err_r, cfg_valid_s, commit_s, apply_s;

   assign edge_s      = i_hsync & ~hsync_r;
   assign line_wrap_s = ({1'b0, vcnt_r} == ({1'b0, active_r.vtot} + 10'd1));

   // Delayed copy of i_hsync for rising-edge detection.
   always_ff @(posedge clk or posedge i_reset) begin
      if (i_reset) hsync_r <= 1'b0;
      else         hsync_r <= i_hsync;
   end

   // FSM state register.
   always_ff @(posedge clk or posedge i_reset) begin
      if (i_reset) state_r <= ST_IDLE;
      else         state_r <= state_nxt_s;
   end

   // FSM next state; a low enable wins over everything.
   always_comb begin
      state_nxt_s = state_r;
      if (!i_en) begin
         state_nxt_s = ST_IDLE;
      end else begin
         case (state_r)
            ST_IDLE: state_nxt_s = ST_ARM;
            ST_ARM:  state_nxt_s = edge_s ? ST_RUN : ST_ARM;
            ST_RUN:  state_nxt_s = ST_RUN;
            default: state_nxt_s = ST_IDLE;
         endcase
      end
   end

   // Counter and pulse next values; everything outside RUN reads as zero.
   always_comb begin
      hcnt_nxt_s  = 9'd0;
      vcnt_nxt_s  = 9'd0;
      hedge_nxt_s = 1'b0;
      frame_nxt_s = 1'b0;
      if (state_nxt_s == ST_RUN) begin
         if (edge_s) begin
            hcnt_nxt_s  = 9'd1;
            hedge_nxt_s = 1'b1;
            if ((state_r == ST_RUN) && !line_wrap_s) vcnt_nxt_s = vcnt_r + 9'd1;
            else                                     vcnt_nxt_s = 9'd1;
            frame_nxt_s = (vcnt_nxt_s == 9'd1);
         end else begin
            hcnt_nxt_s = (hcnt_r == CNT_MAX) ? CNT_MAX : hcnt_r + 9'd1;
            vcnt_nxt_s = vcnt_r;
         end
      end else begin
         hcnt_nxt_s  = 9'd0;
         vcnt_nxt_s  = 9'd0;
      end
   end

   // Registered counters and pulses.
   always_ff @(posedge clk or posedge i_reset) begin
      if (i_reset) begin
         hcnt_r  <= 9'd0;
         vcnt_r  <= 9'd0;
         hedge_r <= 1'b0;
         frame_r <= 1'b0;
      end else begin
         hcnt_r  <= hcnt_nxt_s;
         vcnt_r  <= vcnt_nxt_s;
         hedge_r <= hedge_nxt_s;
         frame_r <= frame_nxt_s;
      end
   end

   // Shadow set as it will be after this cycle; the commit check sees same-cycle writes.
   always_comb begin
      shadow_nxt_s = shadow_r;
      if (cfg.i_cfg_wr && !pending_r) begin
         shadow_nxt_s = cfg_write(shadow_r, cfg.i_cfg_addr, cfg.i_cfg_data);
      end else begin
         shadow_nxt_s = shadow_r;
      end
   end

   out_timing_cfg_check u_cfg_check (
      .shadow    (shadow_nxt_s),
      .cfg_valid (cfg_valid_s)
   );

   assign commit_s = cfg.i_cfg_commit & ~pending_r;
   assign apply_s  = pending_r & ((state_r != ST_RUN) | frame_nxt_s);

   // Shadow/active sets and commit status; shadow is frozen while a commit is pending.
   always_ff @(posedge clk or posedge i_reset) begin
      if (i_reset) begin
         shadow_r  <= CFG_DEFAULT;
         active_r  <= CFG_DEFAULT;
         pending_r <= 1'b0;
         err_r     <= 1'b0;
      end else begin
         shadow_r <= shadow_nxt_s;
         if (apply_s) begin
            active_r  <= shadow_r;
            pending_r <= 1'b0;
         end else if (commit_s) begin
            if (cfg_valid_s) begin
               pending_r <= 1'b1;
               err_r     <= 1'b0;
            end else begin
               err_r     <= 1'b1;
            end
         end
      end
   end

   assign o_hsync_cnt       = hcnt_r;
   assign o_vsync_cnt       = vcnt_r;
   assign o_hsync_edge      = hedge_r;
   assign o_frame_start     = frame_r;
   assign o_VTOT            = active_r.vtot;
   assign o_V_ACTIVE_TH     = active_r.v_active_th;
   assign o_V_WAIT_TH       = active_r.v_wait_th;
   assign o_H_ACTIVE_TH     = active_r.h_active_th;
   assign o_H_WAIT_TH       = active_r.h_wait_th;
   assign o_hsw             = active_r.hsw;
   assign o_vsw             = active_r.vsw;
   assign cfg.o_cfg_pending = pending_r;
   assign cfg.o_cfg_err     = err_r;

endmodule

// File: tb/tb_out_timing_ctrl.sv
// Scoreboard bench for out_timing_ctrl: stimulus updates a line/frame-level
// model and queues the expected line-start report; a monitor checks each pulse.
module tb_out_timing_ctrl;

   logic       clk = 1'b0;
   logic       i_reset, i_en, i_hsync;
   logic [8:0] o_hsync_cnt, o_vsync_cnt, o_VTOT, o_V_ACTIVE_TH, o_V_WAIT_TH;
   logic [8:0] o_H_ACTIVE_TH, o_H_WAIT_TH;
   logic [5:0] o_hsw, o_vsw;
   logic       o_hsync_edge, o_frame_start;

   out_timing_ctrl_if cfg_bus ();

   out_timing_ctrl dut (
      .clk(clk), .i_reset(i_reset), .i_en(i_en), .i_hsync(i_hsync), .cfg(cfg_bus),
      .o_hsync_cnt(o_hsync_cnt), .o_vsync_cnt(o_vsync_cnt), .o_hsync_edge(o_hsync_edge),
      .o_frame_start(o_frame_start), .o_VTOT(o_VTOT), .o_V_ACTIVE_TH(o_V_ACTIVE_TH),
      .o_V_WAIT_TH(o_V_WAIT_TH), .o_H_ACTIVE_TH(o_H_ACTIVE_TH), .o_H_WAIT_TH(o_H_WAIT_TH),
      .o_hsw(o_hsw), .o_vsw(o_vsw)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { int line; int frame; int vtot; int pending; int chk_len; int len; } exp_t;
   exp_t sbq[$];

   int checks = 0;
   int failures = 0;

   // model: 0 idle, 1 armed, 2 running; sets indexed by config address
   int m_state, m_line, m_last_dc, m_pending, m_err;
   int m_act[7];
   int m_sh[7];
   int def_set[7] = '{288, 280, 8, 488, 8, 4, 2};

   function automatic void chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endfunction

   function automatic int cfg_ok(input int s[7]);
      return int'((s[4] < s[3]) && (s[2] < s[1]) && (s[1] <= s[0]) && (s[0] != 511)
                  && (s[6] != 0) && (s[5] != 0));
   endfunction

   task automatic drive(input logic hs, input logic wr, input logic [2:0] a,
                        input logic [8:0] d, input logic cm);
      @(posedge clk);
      #1;
      i_hsync              = hs;
      cfg_bus.i_cfg_wr     = wr;
      cfg_bus.i_cfg_addr   = a;
      cfg_bus.i_cfg_data   = d;
      cfg_bus.i_cfg_commit = cm;
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 1'b0, 3'd0, 9'd0, 1'b0);
   endtask

   task automatic look;
      @(negedge clk);
   endtask

   task automatic en_set(input logic v);
      drive(1'b0, 1'b0, 3'd0, 9'd0, 1'b0);
      i_en = v;
      m_state = v ? ((m_state == 0) ? 1 : m_state) : 0;
   endtask

   // One line start, then idle_after quiet clocks.
   task automatic line(input int idle_after);
      exp_t e;
      drive(1'b1, 1'b0, 3'd0, 9'd0, 1'b0);
      e.chk_len = 0;
      e.len = 0;
      if (m_state == 1) begin
         m_state = 2;
         m_line = 1;
      end else if (m_state == 2) begin
         m_line = (m_line == m_act[0] + 1) ? 1 : m_line + 1;
         e.chk_len = 1;
         e.len = (cyc - m_last_dc > 511) ? 511 : cyc - m_last_dc;
      end
      m_last_dc = cyc;
      if (m_state == 2) begin
         if (m_line == 1 && m_pending != 0) begin
            m_act = m_sh;
            m_pending = 0;
         end
         e.line = m_line;
         e.frame = int'(m_line == 1);
         e.vtot = m_act[0];
         e.pending = m_pending;
         sbq.push_back(e);
      end
      idle(idle_after);
   endtask

   task automatic cfg_op(input logic wr, input logic [2:0] a, input logic [8:0] d, input logic cm);
      drive(1'b0, wr, a, d, cm);
      if (m_pending == 0) begin
         if (wr && a != 3'd7) m_sh[a] = (a >= 3'd5) ? int'(d[5:0]) : int'(d);
         if (cm) begin
            if (cfg_ok(m_sh) != 0) begin
               m_pending = 1;
               m_err = 0;
            end else begin
               m_err = 1;
            end
         end
      end
      if (m_pending != 0 && m_state != 2) begin
         m_act = m_sh;
         m_pending = 0;
      end
   endtask

   task automatic chk_state(input string tag);
      chk({tag, "_pending"}, int'(cfg_bus.o_cfg_pending), m_pending);
      chk({tag, "_err"}, int'(cfg_bus.o_cfg_err), m_err);
      chk({tag, "_VTOT"}, int'(o_VTOT), m_act[0]);
      chk({tag, "_V_ACTIVE_TH"}, int'(o_V_ACTIVE_TH), m_act[1]);
      chk({tag, "_V_WAIT_TH"}, int'(o_V_WAIT_TH), m_act[2]);
      chk({tag, "_H_ACTIVE_TH"}, int'(o_H_ACTIVE_TH), m_act[3]);
      chk({tag, "_H_WAIT_TH"}, int'(o_H_WAIT_TH), m_act[4]);
      chk({tag, "_hsw"}, int'(o_hsw), m_act[5]);
      chk({tag, "_vsw"}, int'(o_vsw), m_act[6]);
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_hcnt"}, int'(o_hsync_cnt), 0);
      chk({tag, "_vcnt"}, int'(o_vsync_cnt), 0);
      chk({tag, "_hedge"}, int'(o_hsync_edge), 0);
      chk({tag, "_frame"}, int'(o_frame_start), 0);
   endtask

   // Monitor: pops one expectation per line-start pulse.
   initial begin : monitor
      exp_t e;
      int   last_hcnt;
      last_hcnt = 0;
      forever begin
         @(negedge clk);
         if (i_reset !== 1'b1) begin
            chk("frame_without_edge", int'(o_frame_start & ~o_hsync_edge), 0);
            if (o_hsync_edge) begin
               if (sbq.size() == 0) begin
                  chk("unexpected_edge", 1, 0);
               end else begin
                  e = sbq.pop_front();
                  chk("edge_hcnt", int'(o_hsync_cnt), 1);
                  chk("edge_vcnt", int'(o_vsync_cnt), e.line);
                  chk("edge_frame_start", int'(o_frame_start), e.frame);
                  chk("edge_VTOT", int'(o_VTOT), e.vtot);
                  chk("edge_pending", int'(cfg_bus.o_cfg_pending), e.pending);
                  if (e.chk_len != 0) chk("line_len", last_hcnt, e.len);
               end
            end
            last_hcnt = int'(o_hsync_cnt);
         end
      end
   end

   initial begin : stimulus
      logic [8:0] rd;
      logic [2:0] ra;
      int         old_vtot;
      i_reset = 1'b1;
      i_en = 1'b0;
      i_hsync = 1'b0;
      cfg_bus.i_cfg_wr = 1'b0;
      cfg_bus.i_cfg_addr = 3'd0;
      cfg_bus.i_cfg_data = 9'd0;
      cfg_bus.i_cfg_commit = 1'b0;
      m_state = 0; m_line = 0; m_last_dc = 0; m_pending = 0; m_err = 0;
      m_act = def_set;
      m_sh = def_set;

      repeat (3) @(posedge clk);
      look;
      chk_quiet("reset");
      chk_state("reset");
      @(posedge clk);
      #1 i_reset = 1'b0;

      en_set(1'b1);
      idle(3);
      look;
      chk_quiet("arm");

      line(599);
      line(999);
      for (int i = 0; i < 300; i++) line(int'($urandom_range(1, 15)));

      for (int g = 0; g < 600 && m_line != 50; g++) line(int'($urandom_range(1, 6)));
      cfg_op(1'b1, 3'd0, 9'd100, 1'b0);
      cfg_op(1'b1, 3'd1, 9'd90, 1'b0);
      cfg_op(1'b0, 3'd0, 9'd0, 1'b1);
      idle(1); look; chk_state("commit_mid_frame");
      cfg_op(1'b1, 3'd4, 9'd500, 1'b1);
      idle(1); look; chk_state("ignored_while_pending");
      for (int g = 0; g < 600 && m_pending != 0; g++) line(int'($urandom_range(1, 6)));
      idle(1); look; chk_state("applied_at_wrap");
      cfg_op(1'b0, 3'd0, 9'd0, 1'b1);
      idle(1); look; chk_state("recommit");
      for (int i = 0; i < 120; i++) line(int'($urandom_range(1, 8)));
      for (int g = 0; g < 600 && m_pending != 0; g++) line(int'($urandom_range(1, 6)));

      cfg_op(1'b1, 3'd4, 9'd500, 1'b1);
      idle(1); look; chk_state("hwait_reject");
      cfg_op(1'b1, 3'd4, 9'd8, 1'b0);

      for (int k = 0; k < 40; k++) begin
         if ($urandom_range(0, 1) == 0) begin
            rd = 9'($urandom);
            ra = 3'($urandom);
            cfg_op(1'($urandom), ra, rd, 1'($urandom));
            idle(1); look; chk_state("random_cfg");
         end else begin
            line(int'($urandom_range(1, 8)));
         end
      end

      for (int g = 0; g < 1200 && m_pending != 0; g++) line(int'($urandom_range(1, 4)));
      cfg_op(1'b1, 3'd0, 9'd200, 1'b0);
      cfg_op(1'b1, 3'd1, 9'd150, 1'b0);
      cfg_op(1'b1, 3'd2, 9'd10, 1'b0);
      cfg_op(1'b1, 3'd3, 9'd300, 1'b0);
      cfg_op(1'b1, 3'd4, 9'd20, 1'b0);
      cfg_op(1'b1, 3'd5, 9'd5, 1'b0);
      cfg_op(1'b1, 3'd6, 9'd3, 1'b1);
      idle(1); look; chk_state("pre_drop");
      old_vtot = m_act[0];
      en_set(1'b0);
      idle(1); look;
      chk_quiet("drop_idle");
      chk("drop_still_pending", int'(cfg_bus.o_cfg_pending), 1);
      chk("drop_vtot_old", int'(o_VTOT), old_vtot);
      m_act = m_sh;
      m_pending = 0;
      idle(1); look; chk_state("drop_applied");

      en_set(1'b1);
      idle(2);
      for (int i = 0; i < 5; i++) line(int'($urandom_range(1, 8)));
      cfg_op(1'b1, 3'd1, 9'd40, 1'b0);
      cfg_op(1'b1, 3'd0, 9'd50, 1'b1);
      idle(1); look; chk_state("pre_reset_pending");

      @(posedge clk);
      #1;
      i_reset = 1'b1;
      i_en = 1'b0;
      m_state = 0; m_line = 0; m_pending = 0; m_err = 0;
      m_act = def_set;
      m_sh = def_set;
      look;
      chk_quiet("reset_mid");
      chk_state("reset_mid");
      idle(2);
      @(posedge clk);
      #1 i_reset = 1'b0;
      en_set(1'b1);
      idle(2);
      for (int i = 0; i < 4; i++) line(int'($urandom_range(2, 9)));
      idle(3);
      chk("scoreboard_drained", sbq.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
